// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the LED matrix frame scanner:
//   - mode_e       : display mode encodings (hold / alternate / single-step)
//   - DEF_*        : default parameter values used by the scanner and timer
//   - decode_mode  : maps the raw 2-bit mode input onto mode_e; the unused
//                    encoding 2'b11 behaves as hold.
// No ports (package).
// -----------------------------------------------------------------------------
package matrix_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD      = 2'b00,
        MODE_ALTERNATE = 2'b01,
        MODE_STEP      = 2'b10
    } mode_e;

    localparam int DEF_COLS         = 5;
    localparam int DEF_ROWS         = 7;
    localparam int DEF_FRAMES       = 2;
    localparam int DEF_SCAN_DIV     = 1000;
    localparam int DEF_FRAME_TICKS  = 250;
    localparam int DEF_BLINK_FRAMES = 2;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_mode = MODE_ALTERNATE;
            2'b10:   decode_mode = MODE_STEP;
            default: decode_mode = MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// -----------------------------------------------------------------------------
// matrix_scan_timer
// Column dwell prescaler and column index for the matrix scanner. Each column
// is held for SCAN_DIV clock cycles; the index walks 0..COLS-1 and wraps.
//
// Ports:
//   clock     in   rising-edge clock
//   reset_n   in   synchronous active-low reset (index and prescaler to 0)
//   col_idx   out  current column index
//   col_adv   out  high in the last cycle of a dwell; the index moves on the
//                  following edge
//   col_wrap  out  col_adv while the index is on the last column (scan wrap)
// -----------------------------------------------------------------------------
module matrix_scan_timer
    import matrix_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [CW-1:0] col_idx,
    output logic          col_adv,
    output logic          col_wrap
);

    logic [PW-1:0] presc;

    assign col_adv  = (presc == PW'(SCAN_DIV - 1));
    assign col_wrap = col_adv && (col_idx == CW'(COLS - 1));

    // Prescaler counts one dwell; at its terminal count the column index
    // steps and the prescaler restarts.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            presc   <= '0;
            col_idx <= '0;
        end else if (col_adv) begin
            presc   <= '0;
            col_idx <= col_wrap ? '0 : col_idx + CW'(1);
        end else begin
            presc   <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/matrix_frame_scanner.sv
// -----------------------------------------------------------------------------
// matrix_frame_scanner
// Multiplexed LED matrix driver with a small multi-frame image buffer.
// Columns are scanned one at a time (one-hot matrix_col) while matrix_row
// carries that column's stored bit pattern. The displayed frame is chosen by
// the mode input; frame changes only take effect at a column-scan wrap.
//
// Optional feature: define MATRIX_BLINK_EN to add the blink input and the
// BLINK_FRAMES parameter (whole-display blinking).
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   synchronous active-low reset (buffer contents kept)
//   wr_en        in   frame buffer write strobe
//   wr_frame     in   frame to write (out-of-range ignored)
//   wr_col       in   column to write (out-of-range ignored)
//   wr_data      in   column pattern, bit i lights row i
//   mode         in   00 hold, 01 alternate, 10 single-step, 11 hold
//   hold_frame   in   frame shown in hold mode (clamped to FRAMES-1)
//   step         in   asynchronous single-step request, rising edge counts
//   blink        in   (MATRIX_BLINK_EN only) enable blinking
//   matrix_row   out  row drive, active-high
//   matrix_col   out  one-hot column enable, active-high
//   frame_index  out  frame currently displayed
//   frame_tick   out  one-cycle pulse whenever frame_index changes
// -----------------------------------------------------------------------------
module matrix_frame_scanner
    import matrix_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int FRAMES       = DEF_FRAMES,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
`ifdef MATRIX_BLINK_EN
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
`endif
    localparam int CW = $clog2(COLS),
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [FW-1:0]   wr_frame,
    input  logic [CW-1:0]   wr_col,
    input  logic [ROWS-1:0] wr_data,
    input  logic [1:0]      mode,
    input  logic [FW-1:0]   hold_frame,
    input  logic            step,
`ifdef MATRIX_BLINK_EN
    input  logic            blink,
`endif
    output logic [ROWS-1:0] matrix_row,
    output logic [COLS-1:0] matrix_col,
    output logic [FW-1:0]   frame_index,
    output logic            frame_tick
);

    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [COLS-1:0] COL_ONE = COLS'(1);

    logic [ROWS-1:0] frame_buf [FRAMES][COLS];

    logic [CW-1:0] col_idx;
    logic          col_adv;
    logic          col_wrap;
    logic          load_q;
    logic          row_dark;

    mode_e         cur_mode;
    logic [TW-1:0] wrap_cnt;
    logic [TW-1:0] wrap_cnt_next;
    logic [FW-1:0] frame_next;
    logic [FW-1:0] frame_adv;
    logic [FW-1:0] hold_target;
    logic [1:0]    step_sync;
    logic          step_prev;
    logic          step_rise;
    logic          step_pending;
    logic          step_pending_next;

    matrix_scan_timer #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .col_idx  (col_idx),
        .col_adv  (col_adv),
        .col_wrap (col_wrap)
    );

    // Image store: written from the host side, never cleared by reset.
    always_ff @(posedge clock) begin
        if (wr_en && (int'(wr_frame) < FRAMES) && (int'(wr_col) < COLS)) begin
            frame_buf[wr_frame][wr_col] <= wr_data;
        end
    end

    assign cur_mode    = decode_mode(mode);
    assign step_rise   = step_sync[1] & ~step_prev;
    assign frame_adv   = (frame_index == FW'(FRAMES - 1)) ? '0 : frame_index + FW'(1);
    assign hold_target = (int'(hold_frame) >= FRAMES) ? FW'(FRAMES - 1) : hold_frame;

    // Frame selection: every mode only changes the frame at a scan wrap so a
    // frame is always shown as a complete image. A step request seen before
    // the wrap is remembered once; further requests until then are dropped.
    always_comb begin
        frame_next        = frame_index;
        wrap_cnt_next     = wrap_cnt;
        step_pending_next = 1'b0;
        case (cur_mode)
            MODE_ALTERNATE: begin
                if (col_wrap) begin
                    if (wrap_cnt == TW'(FRAME_TICKS - 1)) begin
                        wrap_cnt_next = '0;
                        frame_next    = frame_adv;
                    end else begin
                        wrap_cnt_next = wrap_cnt + TW'(1);
                    end
                end
            end
            MODE_STEP: begin
                if (col_wrap) begin
                    wrap_cnt_next = '0;
                    if (step_pending || step_rise) begin
                        frame_next = frame_adv;
                    end
                end else begin
                    step_pending_next = step_pending | step_rise;
                end
            end
            default: begin
                if (col_wrap) begin
                    wrap_cnt_next = '0;
                    frame_next    = hold_target;
                end
            end
        endcase
    end

    // Frame state, step synchroniser and the change pulse, which is raised
    // only when the selected frame actually differs from the current one.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_index  <= '0;
            wrap_cnt     <= '0;
            step_sync    <= '0;
            step_prev    <= 1'b0;
            step_pending <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            frame_index  <= frame_next;
            wrap_cnt     <= wrap_cnt_next;
            step_sync    <= {step_sync[0], step};
            step_prev    <= step_sync[1];
            step_pending <= step_pending_next;
            frame_tick   <= (frame_next != frame_index);
        end
    end

`ifdef MATRIX_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Blink phase flips every BLINK_FRAMES scan wraps; the odd phase is dark.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (col_wrap) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + BW'(1);
            end
        end
    end

    assign row_dark = blink & blink_phase;
`else
    assign row_dark = 1'b0;
`endif

    // Output drive. Rows go dark in the cycle the column index moves, and the
    // new column's pattern is sampled once in the following cycle and held for
    // the rest of the dwell, so a buffer write never shows up mid-dwell.
    // load_q is set by reset so column 0 lights right after reset releases.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            matrix_col <= COL_ONE;
            matrix_row <= '0;
            load_q     <= 1'b1;
        end else begin
            matrix_col <= COL_ONE << col_idx;
            load_q     <= col_adv;
            if (col_adv || row_dark) begin
                matrix_row <= '0;
            end else if (load_q) begin
                matrix_row <= frame_buf[frame_index][col_idx];
            end
        end
    end

endmodule

// File: tb/tb_matrix_frame_scanner.sv
// -----------------------------------------------------------------------------
// tb_matrix_frame_scanner
// Directed bench for matrix_frame_scanner. Main instance: COLS=5, ROWS=7,
// FRAMES=2, SCAN_DIV=4, FRAME_TICKS=3 (one scan wrap every 20 cycles, one
// alternate-mode frame change every 60). A second instance with FRAMES=1
// shares the inputs. Build with MATRIX_BLINK_EN to include the blink scenario.
// Cycle numbering: cyc = n at the negedge following the n-th edge after the
// last reset edge.
// -----------------------------------------------------------------------------
module tb_matrix_frame_scanner;

    localparam int COLS        = 5;
    localparam int ROWS        = 7;
    localparam int FRAMES      = 2;
    localparam int SCAN_DIV    = 4;
    localparam int FRAME_TICKS = 3;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            wr_en;
    logic [0:0]      wr_frame;
    logic [2:0]      wr_col;
    logic [ROWS-1:0] wr_data;
    logic [1:0]      mode;
    logic [0:0]      hold_frame;
    logic            step;
`ifdef MATRIX_BLINK_EN
    logic            blink;
`endif

    logic [ROWS-1:0] matrix_row;
    logic [COLS-1:0] matrix_col;
    logic [0:0]      frame_index;
    logic            frame_tick;

    logic [ROWS-1:0] s_matrix_row;
    logic [COLS-1:0] s_matrix_col;
    logic [0:0]      s_frame_index;
    logic            s_frame_tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [ROWS-1:0] exp_buf [FRAMES][COLS];

    matrix_frame_scanner #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .FRAMES      (FRAMES),
        .SCAN_DIV    (SCAN_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_frame    (wr_frame),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .mode        (mode),
        .hold_frame  (hold_frame),
        .step        (step),
`ifdef MATRIX_BLINK_EN
        .blink       (blink),
`endif
        .matrix_row  (matrix_row),
        .matrix_col  (matrix_col),
        .frame_index (frame_index),
        .frame_tick  (frame_tick)
    );

    matrix_frame_scanner #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .FRAMES      (1),
        .SCAN_DIV    (SCAN_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) dut_single (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_frame    (wr_frame),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .mode        (mode),
        .hold_frame  (hold_frame),
        .step        (step),
`ifdef MATRIX_BLINK_EN
        .blink       (blink),
`endif
        .matrix_row  (s_matrix_row),
        .matrix_col  (s_matrix_col),
        .frame_index (s_frame_index),
        .frame_tick  (s_frame_tick)
    );

    always #5 clock = ~clock;

    // Bench cycle counter, restarted by reset so expectations key off it.
    always @(posedge clock) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [ROWS-1:0] pattern(input int f, input int c);
        logic [ROWS-1:0] base;
        base = (f == 0) ? 7'h55 : 7'h2A;
        pattern = base ^ 7'(c);
    endfunction

    function automatic logic [COLS-1:0] exp_col(input int n);
        int c;
        c = (n < 1) ? 0 : ((n - 1) / SCAN_DIV) % COLS;
        exp_col = 5'b00001 << c;
    endfunction

    function automatic logic [ROWS-1:0] exp_row(input int n, input int f);
        if (n % SCAN_DIV == 0) exp_row = '0;
        else                   exp_row = exp_buf[f][(n / SCAN_DIV) % COLS];
    endfunction

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        wr_en      = 1'b0;
        wr_frame   = '0;
        wr_col     = '0;
        wr_data    = '0;
        mode       = 2'b01;
        hold_frame = '0;
        step       = 1'b0;
`ifdef MATRIX_BLINK_EN
        blink      = 1'b0;
`endif
        for (int f = 0; f < FRAMES; f++) begin
            for (int c = 0; c < COLS; c++) begin
                @(negedge clock);
                wr_en        = 1'b1;
                wr_frame     = 1'(f);
                wr_col       = 3'(c);
                wr_data      = pattern(f, c);
                exp_buf[f][c] = pattern(f, c);
            end
        end
        @(negedge clock);
        wr_en = 1'b0;
        @(negedge clock);
        checks++;
        if (matrix_col !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL reset_col: got %b expected %b", matrix_col, 5'b00001);
        end
        checks++;
        if (matrix_row !== 7'h00) begin
            errors++;
            $display("[TB] FAIL reset_row: got %h expected %h", matrix_row, 7'h00);
        end
        checks++;
        if (frame_index !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_frame: got %0d expected 0", frame_index);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tick: got %b expected 0", frame_tick);
        end
        checks++;
        if (s_matrix_col !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL reset_single_col: got %b expected %b", s_matrix_col, 5'b00001);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_scan;
        while (cyc < 40) begin
            @(negedge clock);
            checks++;
            if (matrix_col !== exp_col(cyc)) begin
                errors++;
                $display("[TB] FAIL scan_col@%0d: got %b expected %b", cyc, matrix_col, exp_col(cyc));
            end
            checks++;
            if (matrix_row !== exp_row(cyc, 0)) begin
                errors++;
                $display("[TB] FAIL scan_row@%0d: got %h expected %h", cyc, matrix_row, exp_row(cyc, 0));
            end
        end
    endtask

    task automatic test_alternate;
        int ef;
        logic et;
        while (cyc < 150) begin
            @(negedge clock);
            ef = (cyc / 60) % 2;
            et = (cyc % 60 == 0);
            checks++;
            if (frame_index !== 1'(ef)) begin
                errors++;
                $display("[TB] FAIL alt_frame@%0d: got %0d expected %0d", cyc, frame_index, ef);
            end
            checks++;
            if (frame_tick !== et) begin
                errors++;
                $display("[TB] FAIL alt_tick@%0d: got %b expected %b", cyc, frame_tick, et);
            end
            checks++;
            if (matrix_row !== exp_row(cyc, ef)) begin
                errors++;
                $display("[TB] FAIL alt_row@%0d: got %h expected %h", cyc, matrix_row, exp_row(cyc, ef));
            end
            checks++;
            if (matrix_col !== exp_col(cyc)) begin
                errors++;
                $display("[TB] FAIL alt_col@%0d: got %b expected %b", cyc, matrix_col, exp_col(cyc));
            end
            checks++;
            if (s_frame_tick !== 1'b0 || s_frame_index !== 1'b0) begin
                errors++;
                $display("[TB] FAIL alt_single@%0d: got tick %b frame %0d expected 0/0", cyc, s_frame_tick, s_frame_index);
            end
        end
    endtask

    task automatic test_hold;
        logic ef;
        logic et;
        // Switch mid-frame while the wrap counter holds one wrap.
        mode       = 2'b00;
        hold_frame = 1'b1;
        while (cyc < 200) begin
            @(negedge clock);
            ef = (cyc >= 160);
            et = (cyc == 160);
            checks++;
            if (frame_index !== ef) begin
                errors++;
                $display("[TB] FAIL hold_frame@%0d: got %0d expected %0d", cyc, frame_index, ef);
            end
            checks++;
            if (frame_tick !== et) begin
                errors++;
                $display("[TB] FAIL hold_tick@%0d: got %b expected %b", cyc, frame_tick, et);
            end
        end
        // Back to alternate: the cleared wrap counter needs three full wraps.
        mode = 2'b01;
        while (cyc < 265) begin
            @(negedge clock);
            ef = (cyc < 260);
            et = (cyc == 260);
            checks++;
            if (frame_index !== ef) begin
                errors++;
                $display("[TB] FAIL hold_realt_frame@%0d: got %0d expected %0d", cyc, frame_index, ef);
            end
            checks++;
            if (frame_tick !== et) begin
                errors++;
                $display("[TB] FAIL hold_realt_tick@%0d: got %b expected %b", cyc, frame_tick, et);
            end
        end
    endtask

    task automatic test_step;
        logic ef;
        logic et;
        mode = 2'b10;
        while (cyc < 305) begin
            @(negedge clock);
            ef = (cyc >= 280);
            et = (cyc == 280);
            checks++;
            if (frame_index !== ef) begin
                errors++;
                $display("[TB] FAIL step_frame@%0d: got %0d expected %0d", cyc, frame_index, ef);
            end
            checks++;
            if (frame_tick !== et) begin
                errors++;
                $display("[TB] FAIL step_tick@%0d: got %b expected %b", cyc, frame_tick, et);
            end
            checks++;
            if (s_frame_tick !== 1'b0 || s_frame_index !== 1'b0) begin
                errors++;
                $display("[TB] FAIL step_single@%0d: got tick %b frame %0d expected 0/0", cyc, s_frame_tick, s_frame_index);
            end
            step = (cyc == 266) || (cyc == 267) || (cyc == 270) || (cyc == 271);
        end
        step = 1'b0;
    endtask

    task automatic test_write_no_tear;
        logic [ROWS-1:0] old_c1;
        old_c1 = exp_buf[1][1];
        wait_until(305);
        checks++;
        if (matrix_row !== old_c1) begin
            errors++;
            $display("[TB] FAIL wr_before@%0d: got %h expected %h", cyc, matrix_row, old_c1);
        end
        wr_en    = 1'b1;
        wr_frame = 1'b1;
        wr_col   = 3'd1;
        wr_data  = 7'h7F;
        @(negedge clock);
        checks++;
        if (matrix_row !== old_c1) begin
            errors++;
            $display("[TB] FAIL wr_no_tear_a@%0d: got %h expected %h", cyc, matrix_row, old_c1);
        end
        wr_col  = 3'd2;
        wr_data = 7'h01;
        @(negedge clock);
        checks++;
        if (matrix_row !== old_c1) begin
            errors++;
            $display("[TB] FAIL wr_no_tear_b@%0d: got %h expected %h", cyc, matrix_row, old_c1);
        end
        wr_en = 1'b0;
        exp_buf[1][1] = 7'h7F;
        exp_buf[1][2] = 7'h01;
        wait_until(309);
        checks++;
        if (matrix_row !== 7'h01) begin
            errors++;
            $display("[TB] FAIL wr_next_col@%0d: got %h expected %h", cyc, matrix_row, 7'h01);
        end
        wait_until(325);
        checks++;
        if (matrix_row !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL wr_next_dwell@%0d: got %h expected %h", cyc, matrix_row, 7'h7F);
        end
        checks++;
        if (frame_index !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_frame_kept@%0d: got %0d expected 1", cyc, frame_index);
        end
    endtask

    task automatic test_mid_reset;
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (matrix_col !== 5'b00001 || matrix_row !== 7'h00) begin
            errors++;
            $display("[TB] FAIL midreset_out: got col %b row %h expected 00001/00", matrix_col, matrix_row);
        end
        checks++;
        if (frame_index !== 1'b0 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_frame: got frame %0d tick %b expected 0/0", frame_index, frame_tick);
        end
        reset_n = 1'b1;
        wait_until(1);
        checks++;
        if (matrix_row !== exp_buf[0][0]) begin
            errors++;
            $display("[TB] FAIL midreset_buf_kept: got %h expected %h", matrix_row, exp_buf[0][0]);
        end
        wait_until(4);
        checks++;
        if (matrix_row !== 7'h00) begin
            errors++;
            $display("[TB] FAIL midreset_blank@%0d: got %h expected 00", cyc, matrix_row);
        end
        wait_until(5);
        checks++;
        if (matrix_col !== 5'b00010 || matrix_row !== exp_buf[0][1]) begin
            errors++;
            $display("[TB] FAIL midreset_col1@%0d: got col %b row %h expected 00010/%h", cyc, matrix_col, matrix_row, exp_buf[0][1]);
        end
    endtask

`ifdef MATRIX_BLINK_EN
    task automatic test_blink;
        logic [ROWS-1:0] er;
        wait_until(80);
        blink = 1'b1;
        while (cyc < 165) begin
            @(negedge clock);
            er = (((cyc / 40) % 2) == 1) ? '0 : exp_row(cyc, 0);
            checks++;
            if (matrix_row !== er) begin
                errors++;
                $display("[TB] FAIL blink_row@%0d: got %h expected %h", cyc, matrix_row, er);
            end
        end
        blink = 1'b0;
    endtask
`endif

    initial begin
        $display("[TB] matrix_frame_scanner directed bench start");
        test_reset();
        test_scan();
        test_alternate();
        test_hold();
        test_step();
        test_write_no_tear();
        test_mid_reset();
`ifdef MATRIX_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
